// File: rtl/time_set_controller.sv
// time_set_controller: mode/up/down key handler for a clock-setting UI.
// Steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN on mode presses.
// Issues single-cycle add/sub pulses to the field being set.
// Drives a blink request for the field being set.
// Optional feature macro: TIME_SET_AUTO_REPEAT_EN enables auto-repeat of held up/down keys.
module time_set_controller #(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int BLINK_HALF    = 250
) (
    input  logic       clk_src,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] add_time,
    output logic [2:0] sub_time,
    output logic       enable,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    // blink counter only ever reaches BLINK_HALF-1, so $clog2(BLINK_HALF) bits suffice
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    state_t        state, state_nxt;
    logic          mode_q, up_q, down_q;
    logic          mode_rise, up_rise, down_rise;
    logic          in_set;
    logic [2:0]    field;
    logic          lock;
    logic          press_up, press_down;
    logic          rpt_up, rpt_down;
    logic          fire_up, fire_down;
    logic [BW-1:0] blink_cnt;

    // Previous key levels; loaded in reset too so releasing reset never creates an edge
    always_ff @(posedge clk_src) begin
        mode_q <= btn_mode;
        up_q   <= btn_up;
        down_q <= btn_down;
    end

    assign mode_rise = btn_mode & ~mode_q;
    assign up_rise   = btn_up   & ~up_q;
    assign down_rise = btn_down & ~down_q;

    // State register
    always_ff @(posedge clk_src) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state on mode edge; field select and run enable from current state
    always_comb begin
        state_nxt = state;
        field     = 3'b000;
        enable    = 1'b0;
        mode      = state;
        unique case (state)
            RUN: begin
                enable = 1'b1;
                if (mode_rise) state_nxt = SET_HOUR;
            end
            SET_HOUR: begin
                field = 3'b100;
                if (mode_rise) state_nxt = SET_MIN;
            end
            SET_MIN: begin
                field = 3'b010;
                if (mode_rise) state_nxt = SET_SEC;
            end
            SET_SEC: begin
                field = 3'b001;
                if (mode_rise) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign in_set = (state != RUN);

    // Lockout: keys held over a state change, or up+down together, are dead until all released
    always_ff @(posedge clk_src) begin
        if (!reset)                        lock <= 1'b0;
        else if (!btn_up && !btn_down)     lock <= 1'b0;
        else if (mode_rise || (btn_up && btn_down)) lock <= 1'b1;
    end

    // A fresh press only counts alone, unlocked, in a SET state, and when mode is not also moving
    assign press_up   = in_set & up_rise   & ~btn_down & ~lock & ~mode_rise;
    assign press_down = in_set & down_rise & ~btn_up   & ~lock & ~mode_rise;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic          rpt_armed, rpt_phase, rpt_ok, rpt_hit;
    logic [RW-1:0] rpt_cnt;

    // Repeat continues only while exactly one key stays held, unlocked, in a SET state
    assign rpt_ok  = in_set & ~lock & ~mode_rise & (btn_up ^ btn_down);
    assign rpt_hit = rpt_armed & tick &
                     (rpt_cnt == (rpt_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));
    assign rpt_up   = rpt_ok & rpt_hit & btn_up;
    assign rpt_down = rpt_ok & rpt_hit & btn_down;

    // Repeat timer: armed by a press, first gap REPEAT_DELAY, then REPEAT_PERIOD; saturates
    always_ff @(posedge clk_src) begin
        if (!reset || !rpt_ok) begin
            rpt_armed <= 1'b0;
            rpt_phase <= 1'b0;
            rpt_cnt   <= '0;
        end else if (press_up || press_down) begin
            rpt_armed <= 1'b1;
            rpt_phase <= 1'b0;
            rpt_cnt   <= '0;
        end else if (rpt_hit) begin
            rpt_phase <= 1'b1;
            rpt_cnt   <= '0;
        end else if (rpt_armed && tick && rpt_cnt != {RW{1'b1}}) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rpt_up   = 1'b0;
    assign rpt_down = 1'b0;
`endif

    assign fire_up   = press_up   | rpt_up;
    assign fire_down = press_down | rpt_down;

    // Registered pulse outputs; up and down are mutually exclusive so at most one bit is set
    always_ff @(posedge clk_src) begin
        if (!reset) begin
            add_time <= 3'b000;
            sub_time <= 3'b000;
        end else begin
            add_time <= fire_up   ? field : 3'b000;
            sub_time <= fire_down ? field : 3'b000;
        end
    end

    // Blink: blanked on SET entry, unblanked after an edit, toggles every BLINK_HALF ticks
    always_ff @(posedge clk_src) begin
        if (!reset) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (mode_rise) begin
            blink     <= (state_nxt != RUN);
            blink_cnt <= '0;
        end else if (!in_set || fire_up || fire_down) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: vector table plus multi-cycle sequences.
module tb_time_set_controller;

    logic       clk_src = 1'b0;
    logic       reset, tick, btn_mode, btn_up, btn_down;
    logic [2:0] add_time, sub_time;
    logic       enable, blink;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    always #5 clk_src = ~clk_src;

    time_set_controller dut (
        .clk_src (clk_src),
        .reset   (reset),
        .tick    (tick),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .add_time(add_time),
        .sub_time(sub_time),
        .enable  (enable),
        .mode    (mode),
        .blink   (blink)
    );

    typedef struct {
        logic       m, u, d;
        logic [1:0] e_mode;
        logic       e_en, e_blink;
        logic [2:0] e_add, e_sub;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic m, logic u, logic d, logic [1:0] em, logic een,
                                logic eb, logic [2:0] ea, logic [2:0] es);
        vec_t v;
        v.m = m; v.u = u; v.d = d;
        v.e_mode = em; v.e_en = een; v.e_blink = eb; v.e_add = ea; v.e_sub = es;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // advance one clock, sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk_src);
        #1;
    endtask

    function automatic int outs();
        return int'({mode, enable, blink, add_time, sub_time});
    endfunction

    task automatic press_mode();
        btn_mode = 1'b1; step();
        btn_mode = 1'b0; step();
    endtask

    int n_pulse, n_bad, second_at, expect_rpt;

    initial begin
        //                 m  u  d  mode en blk add     sub
        vecs[0]  = mk(1, 0, 0, 1, 0, 1, 3'b000, 3'b000);
        vecs[1]  = mk(0, 0, 0, 1, 0, 1, 3'b000, 3'b000);
        vecs[2]  = mk(1, 0, 0, 2, 0, 1, 3'b000, 3'b000);
        vecs[3]  = mk(0, 0, 0, 2, 0, 1, 3'b000, 3'b000);
        vecs[4]  = mk(0, 1, 0, 2, 0, 0, 3'b010, 3'b000);
        vecs[5]  = mk(0, 1, 0, 2, 0, 0, 3'b000, 3'b000);
        vecs[6]  = mk(0, 0, 0, 2, 0, 0, 3'b000, 3'b000);
        vecs[7]  = mk(1, 0, 0, 3, 0, 1, 3'b000, 3'b000);
        vecs[8]  = mk(0, 0, 0, 3, 0, 1, 3'b000, 3'b000);
        vecs[9]  = mk(0, 0, 1, 3, 0, 0, 3'b000, 3'b001);
        vecs[10] = mk(0, 0, 0, 3, 0, 0, 3'b000, 3'b000);
        vecs[11] = mk(1, 0, 0, 0, 1, 0, 3'b000, 3'b000);
        vecs[12] = mk(0, 0, 0, 0, 1, 0, 3'b000, 3'b000);
        vecs[13] = mk(0, 0, 1, 0, 1, 0, 3'b000, 3'b000);
        vecs[14] = mk(0, 0, 0, 0, 1, 0, 3'b000, 3'b000);
        vecs[15] = mk(0, 1, 0, 0, 1, 0, 3'b000, 3'b000);
        vecs[16] = mk(1, 1, 0, 1, 0, 1, 3'b000, 3'b000);
        vecs[17] = mk(0, 1, 0, 1, 0, 1, 3'b000, 3'b000);
        vecs[18] = mk(0, 0, 0, 1, 0, 1, 3'b000, 3'b000);
        vecs[19] = mk(0, 1, 0, 1, 0, 0, 3'b100, 3'b000);
        vecs[20] = mk(0, 0, 0, 1, 0, 0, 3'b000, 3'b000);
        vecs[21] = mk(1, 1, 0, 2, 0, 1, 3'b000, 3'b000);
        vecs[22] = mk(0, 1, 0, 2, 0, 1, 3'b000, 3'b000);
        vecs[23] = mk(0, 0, 0, 2, 0, 1, 3'b000, 3'b000);
        vecs[24] = mk(0, 1, 0, 2, 0, 0, 3'b010, 3'b000);
        vecs[25] = mk(0, 0, 0, 2, 0, 0, 3'b000, 3'b000);

        reset = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        step(); step();
        chk("reset_outputs", outs(), int'({2'd0, 1'b1, 1'b0, 3'b000, 3'b000}));
        reset = 1'b1;
        step();
        chk("post_reset_idle", outs(), int'({2'd0, 1'b1, 1'b0, 3'b000, 3'b000}));

        // table: tick held low so blink only moves on entry/edit
        foreach (vecs[i]) begin
            btn_mode = vecs[i].m; btn_up = vecs[i].u; btn_down = vecs[i].d;
            step();
            chk($sformatf("vec%0d", i), outs(),
                int'({vecs[i].e_mode, vecs[i].e_en, vecs[i].e_blink, vecs[i].e_add, vecs[i].e_sub}));
        end

        // blink half-period: enter SET_SEC then count ticks
        press_mode();
        chk("blink_entry", int'({mode, blink}), int'({2'd3, 1'b1}));
        tick = 1'b1;
        for (int i = 0; i < 249; i++) step();
        chk("blink_249", int'(blink), 1);
        step();
        chk("blink_250", int'(blink), 0);
        tick = 1'b0;

        // held up in SET_SEC for 805 ticks
        n_pulse = 0; n_bad = 0; second_at = -1;
        tick = 1'b1; btn_up = 1'b1;
        for (int i = 0; i < 808; i++) begin
            if (i == 805) btn_up = 1'b0;
            step();
            if (add_time[0]) begin
                n_pulse++;
                if (n_pulse == 2) second_at = i;
            end
            if ($countones({add_time, sub_time}) > 1 || add_time[2:1] != 0 || sub_time != 0) n_bad++;
        end
        tick = 1'b0;
`ifdef TIME_SET_AUTO_REPEAT_EN
        expect_rpt = 5;
        chk("repeat_first_gap", second_at, 500);
`else
        expect_rpt = 1;
        chk("no_repeat_second", second_at, -1);
`endif
        chk("repeat_count", n_pulse, expect_rpt);
        chk("repeat_clean_bits", n_bad, 0);

        // SET_SEC -> RUN -> SET_HOUR, then both keys held 2000 ticks
        press_mode(); press_mode();
        chk("hour_mode", int'(mode), 1);
        n_pulse = 0;
        tick = 1'b1; btn_up = 1'b1; btn_down = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            n_pulse += $countones({add_time, sub_time});
        end
        btn_up = 1'b0; btn_down = 1'b0;
        step();
        n_pulse += $countones({add_time, sub_time});
        chk("both_keys_no_pulse", n_pulse, 0);
        tick = 1'b0;
        btn_up = 1'b1;
        step();
        chk("after_both_up", int'({add_time, sub_time}), int'({3'b100, 3'b000}));
        step();
        chk("after_both_single", int'(add_time), 0);

        // reset while up is held mid-repeat
        tick = 1'b1;
        for (int i = 0; i < 520; i++) step();
        reset = 1'b0;
        step();
        chk("midrpt_reset", outs(), int'({2'd0, 1'b1, 1'b0, 3'b000, 3'b000}));
        reset = 1'b1;
        step();
        chk("midrpt_release", outs(), int'({2'd0, 1'b1, 1'b0, 3'b000, 3'b000}));
        // first press after reset with up still held: enter SET_HOUR, held key locked out
        btn_mode = 1'b1; step();
        btn_mode = 1'b0;
        n_pulse = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            n_pulse += $countones({add_time, sub_time});
        end
        chk("held_over_reset_locked", n_pulse, 0);
        btn_up = 1'b0; tick = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 Parameter REPEAT_DELAY, default 500, meaning: ticks a key is held before auto-repeat starts.
REQ-002 Parameter REPEAT_PERIOD, default 100, meaning: ticks between auto-repeat pulses.
REQ-003 Parameter BLINK_HALF, default 250, meaning: ticks per blink half-period.
REQ-004 clk_src  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 tick  input  1  single-cycle timebase strobe (nominal 1 kHz); all tick-counted timing advances only on tick=1.
REQ-007 btn_mode  input  1  mode key, synchronized level, 1 = pressed.
REQ-008 btn_up  input  1  increment key, synchronized level, 1 = pressed.
REQ-009 btn_down  input  1  decrement key, synchronized level, 1 = pressed.
REQ-010 add_time  output  3  one-cycle increment pulses to timers; bit0 sec, bit1 min, bit2 hour.
REQ-011 sub_time  output  3  one-cycle decrement pulses; same bit mapping.
REQ-012 enable  output  1  timer run enable; 1 only in RUN.
REQ-013 mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
REQ-014 blink  output  1  display blank request for the field being set.

Function
REQ-015 Block SHALL detect rising edges of btn_mode, btn_up, btn_down from registered previous levels.
REQ-016 FSM SHALL advance RUN->SET_HOUR->SET_MIN->SET_SEC->RUN on each btn_mode rising edge, one state per edge; mode output updates the cycle after the edge is sampled.
REQ-017 In RUN, btn_up/btn_down SHALL be ignored; add_time and sub_time SHALL stay 0.
REQ-018 In SET_x, btn_up rising edge SHALL produce add_time[x]=1 for exactly one cycle, the cycle after the edge is sampled; btn_down likewise on sub_time[x].
REQ-019 At most one bit of add_time|sub_time SHALL be high in any cycle.
REQ-020 If btn_up and btn_down are both high, no pulse SHALL issue and the repeat counter SHALL hold at 0 until both are released.
REQ-021 A btn_mode edge coinciding with an up/down edge SHALL win: state changes, no add/sub pulse issues, and the held key is ignored until released.
REQ-022 Keys held across a state change SHALL be ignored until released (no auto-repeat carry-over).
REQ-023 blink SHALL be 0 in RUN; in SET states it SHALL toggle every BLINK_HALF ticks, restarting at 1 (blanked) on each state entry and forced to 0 for BLINK_HALF ticks after any add/sub pulse.
REQ-024 Tick counters SHALL be sized by $clog2 of their largest parameter and saturate, never wrap.

Reset
REQ-025 With reset=0 at a clock edge: state RUN, mode=0, enable=1, blink=0, add_time=0, sub_time=0, all edge registers loaded with current key levels (no edge on release of reset), all counters 0.
REQ-026 Reset mid-repeat or mid-blink SHALL abort immediately; no pulse issues in the cycle after reset deasserts.

Configuration
REQ-027 Macro TIME_SET_AUTO_REPEAT_EN defined: a key held REPEAT_DELAY ticks after its first pulse SHALL issue a further pulse, then one every REPEAT_PERIOD ticks while held alone, in SET states only.
REQ-028 Macro undefined: exactly one pulse per key press; repeat counters not instantiated; REPEAT_DELAY and REPEAT_PERIOD unused.

Verification
REQ-029 Reset with all keys low, then 4 btn_mode presses -> mode 1,2,3,0; enable 0 in modes 1-3, 1 in 0.
REQ-030 mode=2, single btn_up press -> add_time=3'b010 for one cycle, one cycle after edge; all other pulse bits 0.
REQ-031 mode=0, btn_down press -> sub_time stays 3'b000, enable stays 1.
REQ-032 mode=1, btn_up and btn_down held together 2000 ticks -> no pulses; release then btn_up -> one add_time=3'b100.
REQ-033 With TIME_SET_AUTO_REPEAT_EN, mode=3, btn_up held 800 ticks (defaults) -> pulses at press, +500, +600, +700, +800 ticks (5 total on add_time[0]); without macro -> 1 pulse.
REQ-034 mode=1 with btn_up held, btn_mode pressed -> mode=2, no add_time pulse until btn_up released and pressed again.
